fifo_rd_serializer: RTL and testbench
=====================================

Name: fifo_rd_serializer

Overview:
- Read-side consumer for the async FIFO, running entirely in the read clock domain.
- Pops DATA_WIDTH-bit words from the FIFO read port and emits them as OUT_WIDTH-bit beats on a valid/ready stream, least-significant slice first.
- Hides the FIFO's one-cycle registered read latency with a 2-word prefetch buffer, so back-to-back streaming runs with no bubbles.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, stream beat width.
- RATIO, DATA_WIDTH/OUT_WIDTH, derived (localparam), beats per word; RATIO=1 is legal and acts as a pure prefetch/skid stage.

Ports:
- rd_clk  in  1  read-domain clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  FIFO empty flag, already in the rd_clk domain.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid on the cycle after an accepted pop.
- m_data  out  OUT_WIDTH  stream beat.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high on the final beat of each word.
- buf_count  out  2  number of words held in the buffer (0..2).

Behaviour:
- Reset (async assert, sync release): buffer empty, beat_idx=0, inflight=0, m_valid=0, m_data=0, m_last=0, buf_count=0, fifo_rd_en=0.
- Pop accepted: pop_acc = fifo_rd_en & ~fifo_empty.
- Word capture: inflight register <= pop_acc. When inflight=1, fifo_data is written into the buffer that cycle.
- Buffer structure: 2-entry FIFO, slot0 = head. Capture goes into the first free slot, computed after any same-cycle head retire.
- Beat handshake: beat_fire = m_valid & m_ready.
  - m_valid = (buf_count != 0).
  - m_data = slot0[beat_idx*OUT_WIDTH +: OUT_WIDTH].
  - m_last = m_valid & (beat_idx == RATIO-1).
- Word retire: word_pop = beat_fire & m_last.
  - On word_pop: slot1 shifts to slot0 and beat_idx resets to 0.
  - On any other beat_fire: beat_idx increments.
- Outputs m_data, m_valid and m_last are combinational from registered state only; no combinational path from m_ready to them.
- Prefetch rule: fifo_rd_en = ~rst & ~fifo_empty & ((buf_count + inflight - word_pop) < 2).
  - This contains a combinational path m_ready -> fifo_rd_en, accepted by design.
  - Guarantees no overflow: occupancy never exceeds 2.
- Latency: first beat appears 2 cycles after fifo_empty deasserts (pop issued, data captured, m_valid next cycle).
- Throughput: sustained 1 beat/cycle for any RATIO while the FIFO is non-empty and m_ready=1.
- Stream protocol: m_data and m_last are held stable while m_valid & ~m_ready.
- Simultaneous capture and word_pop with a full buffer cannot happen (excluded by the prefetch rule).
- Simultaneous capture and word_pop with buf_count=1: captured word lands in slot0 and buf_count stays 1.
- FIFO empty: fifo_rd_en stays 0; the buffer drains normally.
- beat_idx width: $clog2(RATIO), minimum 1 bit; it wraps only through the word_pop path.
- Reset mid-word: partially sent word and any in-flight word are discarded. The upstream FIFO is reset together with this block.

Decomposition:
- Shared package fifo_rd_pkg:
  - ratio helper function and beat index width function.
  - typedef for buffer occupancy (2-bit).
- One natural sub-module: prefetch_buf2, the 2-entry word buffer with push/pop/count. The serializer mux and prefetch control stay in the top.

Test Plan:
- Reset then fifo_empty=0 with words 0x44332211, 0x88776655, m_ready=1 -> fifo_rd_en rises the cycle after reset release; beats 11,22,33,44(last),55,66,77,88(last) on consecutive cycles; first beat 2 cycles after the first pop.
- Continuous FIFO supply of 8 words, m_ready=1 -> 32 beats in 32 consecutive cycles, no bubbles; buf_count never exceeds 2.
- m_ready held 0 for 10 cycles mid-word at beat 2 -> m_data=0x33 and m_valid held stable; fifo_rd_en deasserts once buf_count+inflight=2; resumes with no data lost or duplicated.
- RATIO=1 (OUT_WIDTH=32), m_ready toggling 1,0,1,0 -> every word emitted exactly once in order; m_last=1 on every beat.
- FIFO goes empty after 1 word -> 4 beats, then m_valid=0 and fifo_rd_en=0; a later refill restarts with the 2-cycle latency.
- rst pulsed while beat_idx=2 with a pop in flight -> all outputs 0 immediately (asynchronous); after release, buf_count=0 and the next word starts at beat 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: definitions shared by the FIFO read-side serializer.
//   ratio_of()    - beats per FIFO word (DATA_WIDTH / OUT_WIDTH)
//   beat_idx_w()  - width of the beat index, never less than 1 bit
//   occ_t         - word-buffer occupancy, 0..2
package fifo_rd_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_MAX = 2'd2;

  function automatic int ratio_of(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  // A single-beat word still needs a 1-bit index so that the index
  // register and compare logic keep a legal width.
  function automatic int beat_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/prefetch_buf2.sv
// prefetch_buf2: two-entry word buffer, slot0 is the head.
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data into the first free slot
//   push_data  - word to store
//   pop        - retire the head word (slot1 moves to slot0)
//   head       - current head word (slot0)
//   count      - number of words held (0..2)
// The free slot is chosen after a same-cycle pop, so a push that
// coincides with retiring the only word lands directly in slot0.
module prefetch_buf2
  import fifo_rd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output occ_t         count
);

  logic [W-1:0] slot0_reg;
  logic [W-1:0] slot1_reg;
  occ_t         count_reg;
  occ_t         after_pop;

  // Occupancy once the head has retired; this is also the index of the
  // slot a push writes into (the caller never pushes into a full buffer).
  assign after_pop = count_reg - occ_t'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_reg <= '0;
      slot1_reg <= '0;
      count_reg <= '0;
    end else begin
      if (push && (after_pop == 2'd0)) begin
        slot0_reg <= push_data;
      end else if (pop) begin
        slot0_reg <= slot1_reg;
      end
      if (push && (after_pop == 2'd1)) begin
        slot1_reg <= push_data;
      end
      count_reg <= after_pop + occ_t'(push);
    end
  end

  assign head  = slot0_reg;
  assign count = count_reg;

endmodule

// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: pops DATA_WIDTH-bit words from a FIFO read port and
// streams them as OUT_WIDTH-bit beats, least-significant slice first.
//   rd_clk, rst    - clock, asynchronous active-high reset
//   fifo_empty     - FIFO empty flag (rd_clk domain)
//   fifo_rd_en     - FIFO pop request
//   fifo_data      - FIFO read data, valid the cycle after an accepted pop
//   m_data         - stream beat
//   m_valid        - beat valid
//   m_ready        - downstream ready
//   m_last         - final beat of the current word
//   buf_count      - words held in the prefetch buffer (0..2)
// DATA_WIDTH must be an integer multiple of OUT_WIDTH. A two-word buffer
// hides the FIFO's registered read latency so streaming has no bubbles.
module fifo_rd_serializer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            buf_count
);

  localparam int RATIO = ratio_of(DATA_WIDTH, OUT_WIDTH);
  localparam int IDX_W = beat_idx_w(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic                  inflight_reg;
  logic [IDX_W-1:0]      beat_idx_reg;
  logic [DATA_WIDTH-1:0] head;
  occ_t                  count;
  logic                  beat_fire;
  logic                  word_pop;
  logic                  pop_acc;
  logic [2:0]            occ_after;
  logic [OUT_WIDTH-1:0]  slice [RATIO];

  prefetch_buf2 #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (fifo_data),
    .pop       (word_pop),
    .head      (head),
    .count     (count)
  );

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign slice[gi] = head[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  // Stream outputs depend only on registered state, never on m_ready.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_idx_reg == IDX_W'(i)) begin
        m_data = slice[i];
      end
    end
  end

  assign m_valid   = (count != 2'd0);
  assign m_last    = m_valid & (beat_idx_reg == LAST_IDX);
  assign buf_count = count;

  assign beat_fire = m_valid & m_ready;
  assign word_pop  = beat_fire & m_last;

  // Words held plus the one in flight, after this cycle's retire. Keeping
  // this below 2 before popping guarantees a free slot when data lands.
  // The word_pop term gives a combinational m_ready -> fifo_rd_en path,
  // which is what allows RATIO=1 to sustain one word per cycle.
  assign occ_after  = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, word_pop};
  assign fifo_rd_en = ~rst & ~fifo_empty & (occ_after < {1'b0, OCC_MAX});
  assign pop_acc    = fifo_rd_en & ~fifo_empty;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      beat_idx_reg <= '0;
    end else begin
      inflight_reg <= pop_acc;
      if (word_pop) begin
        beat_idx_reg <= '0;
      end else if (beat_fire) begin
        beat_idx_reg <= beat_idx_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: a 32/8 instance (dut_a) and a 32/32
// instance (dut_b). Each has a queue-based FIFO model and an expected
// beat queue built from the words pushed (slices LSB first, last flag on
// the final slice).
module tb_fifo_rd_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fe_a, rd_a, mv_a, mr_a, ml_a;
  logic [31:0] fd_a;
  logic [7:0]  md_a;
  logic [1:0]  bc_a;
  logic        fe_b, rd_b, mv_b, mr_b, ml_b;
  logic [31:0] fd_b;
  logic [31:0] md_b;
  logic [1:0]  bc_b;

  fifo_rd_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut_a (
    .rd_clk(clk), .rst(rst), .fifo_empty(fe_a), .fifo_rd_en(rd_a),
    .fifo_data(fd_a), .m_data(md_a), .m_valid(mv_a), .m_ready(mr_a),
    .m_last(ml_a), .buf_count(bc_a)
  );

  fifo_rd_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(32)) dut_b (
    .rd_clk(clk), .rst(rst), .fifo_empty(fe_b), .fifo_rd_en(rd_b),
    .fifo_data(fd_b), .m_data(md_b), .m_valid(mv_b), .m_ready(mr_b),
    .m_last(ml_b), .buf_count(bc_b)
  );

  int total = 0;
  int bad = 0;
  int fired_a = 0;
  int fired_b = 0;
  int f0, n, base;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [8:0]  exp_a[$];
  logic [32:0] exp_b[$];

  logic rst_req, mr_a_req, mr_b_req, stall_a_req;
  logic hold_a, hold_b;
  logic [8:0]  held_a;
  logic [32:0] held_b;

  // FIFO models: registered read data, one cycle after an accepted pop.
  always @(posedge clk) begin
    if (rd_a && !fe_a && q_a.size() != 0) fd_a <= q_a.pop_front();
    if (rd_b && !fe_b && q_b.size() != 0) fd_b <= q_b.pop_front();
  end

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic push_a(input logic [31:0] w);
    q_a.push_back(w);
    for (int i = 0; i < 4; i++) exp_a.push_back({(i == 3), w[8*i +: 8]});
  endtask

  task automatic push_b(input logic [31:0] w);
    q_b.push_back(w);
    exp_b.push_back({1'b1, w});
  endtask

  // One cycle: drive inputs on the falling edge, sample 1 time unit later.
  // A beat counts as transferred when valid and ready are both seen here.
  task automatic tick();
    logic [8:0]  e;
    logic [32:0] eb;
    @(negedge clk);
    rst  = rst_req;
    mr_a = mr_a_req;
    mr_b = mr_b_req;
    fe_a = (q_a.size() == 0) || stall_a_req;
    fe_b = (q_b.size() == 0);
    #1;
    if (hold_a && !rst) begin
      chk("a_hold_valid", 33'(mv_a), 33'(1));
      chk("a_hold_beat", 33'({ml_a, md_a}), 33'(held_a));
    end
    if (!rst && mv_a && mr_a) begin
      fired_a++;
      chk("a_beat_avail", 33'(exp_a.size() != 0), 33'(1));
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_beat", 33'({ml_a, md_a}), 33'(e));
      end
    end
    chk("a_buf_count_max", 33'(bc_a <= 2'd2), 33'(1));
    hold_a = !rst && mv_a && !mr_a;
    held_a = {ml_a, md_a};
    if (hold_b && !rst) begin
      chk("b_hold_valid", 33'(mv_b), 33'(1));
      chk("b_hold_data", 33'(md_b), 33'(held_b[31:0]));
    end
    if (!rst && mv_b && mr_b) begin
      fired_b++;
      chk("b_beat_avail", 33'(exp_b.size() != 0), 33'(1));
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        chk("b_beat_data", 33'(md_b), 33'(eb[31:0]));
        chk("b_last", 33'(ml_b), 33'(eb[32]));
      end
    end
    hold_b = !rst && mv_b && !mr_b;
    held_b = {ml_b, md_b};
    $display("t=%0t a: v=%0b r=%0b d=%h l=%0b bc=%0d rd=%0b | b: v=%0b r=%0b d=%h l=%0b",
             $time, mv_a, mr_a, md_a, ml_a, bc_a, rd_a, mv_b, mr_b, md_b, ml_b);
  endtask

  task automatic drain_a(input int limit);
    int k;
    k = 0;
    mr_a_req = 1'b1;
    stall_a_req = 1'b0;
    while ((exp_a.size() != 0 || mv_a) && k < limit) begin
      tick();
      k++;
    end
    chk("a_drain_done", 33'(exp_a.size()), 33'(0));
    chk("a_drain_valid", 33'(mv_a), 33'(0));
  endtask

  initial begin
    rst = 1'b1; rst_req = 1'b1;
    mr_a_req = 1'b1; mr_b_req = 1'b0; stall_a_req = 1'b0;
    mr_a = 1'b0; mr_b = 1'b0; fe_a = 1'b1; fe_b = 1'b1;
    fd_a = '0; fd_b = '0;
    hold_a = 1'b0; hold_b = 1'b0; held_a = '0; held_b = '0;

    // Reset state.
    repeat (3) tick();
    chk("rst_m_valid", 33'(mv_a), 33'(0));
    chk("rst_m_data", 33'(md_a), 33'(0));
    chk("rst_m_last", 33'(ml_a), 33'(0));
    chk("rst_buf_count", 33'(bc_a), 33'(0));
    chk("rst_rd_en", 33'(rd_a), 33'(0));
    chk("rst_b_valid", 33'(mv_b), 33'(0));

    // Two words, ready high: pop right after release, 2-cycle latency, 8 beats.
    push_a(32'h44332211);
    push_a(32'h88776655);
    tick();
    chk("rst_rd_en_held", 33'(rd_a), 33'(0));
    rst_req = 1'b0;
    tick();
    chk("t1_rd_en_rise", 33'(rd_a), 33'(1));
    chk("t1_valid_c0", 33'(mv_a), 33'(0));
    tick();
    chk("t1_valid_c1", 33'(mv_a), 33'(0));
    f0 = fired_a;
    tick();
    chk("t1_first_valid", 33'(mv_a), 33'(1));
    chk("t1_first_beat", 33'(md_a), 33'(8'h11));
    repeat (7) tick();
    chk("t1_no_bubble", 33'(fired_a - f0), 33'(8));
    tick();
    chk("t1_drained_valid", 33'(mv_a), 33'(0));
    chk("t1_drained_rd", 33'(rd_a), 33'(0));

    // Refill after empty: same 2-cycle latency.
    push_a(32'h0D0C0B0A);
    tick();
    chk("t5_rd_en", 33'(rd_a), 33'(1));
    tick();
    chk("t5_valid_c1", 33'(mv_a), 33'(0));
    tick();
    chk("t5_valid_c2", 33'(mv_a), 33'(1));
    chk("t5_first_beat", 33'(md_a), 33'(8'h0A));
    drain_a(20);
    chk("t5_rd_idle", 33'(rd_a), 33'(0));

    // Eight words back to back: 32 beats in 32 cycles.
    for (int i = 0; i < 8; i++) push_a($urandom);
    f0 = fired_a;
    n = 0;
    while (!mv_a && n < 10) begin tick(); n++; end
    chk("t2_started", 33'(mv_a), 33'(1));
    repeat (31) tick();
    chk("t2_32_beats", 33'(fired_a - f0), 33'(32));
    tick();
    chk("t2_empty_after", 33'(mv_a), 33'(0));

    // Back-pressure for 10 cycles on beat 2 of 0x44332211.
    push_a(32'h44332211);
    for (int i = 0; i < 5; i++) push_a($urandom);
    base = fired_a;
    n = 0;
    while ((fired_a - base) != 2 && n < 20) begin tick(); n++; end
    mr_a_req = 1'b0;
    repeat (10) begin
      tick();
      chk("t3_stall_valid", 33'(mv_a), 33'(1));
      chk("t3_stall_data", 33'(md_a), 33'(8'h33));
    end
    chk("t3_buf_full", 33'(bc_a), 33'(2));
    chk("t3_rd_off", 33'(rd_a), 33'(0));
    drain_a(100);

    // Random ready / FIFO stalls / supply.
    repeat (400) begin
      mr_a_req = ($urandom_range(0, 3) != 0);
      stall_a_req = ($urandom_range(0, 4) == 0);
      if (q_a.size() < 3 && $urandom_range(0, 1) == 1) push_a($urandom);
      tick();
    end
    drain_a(200);

    // Reset while beat_idx=2 with a pop in flight.
    push_a(32'h44332211);
    tick();
    tick();
    tick();
    chk("t6_beat0", 33'(md_a), 33'(8'h11));
    push_a(32'h88776655);
    tick();
    chk("t6_beat1", 33'(md_a), 33'(8'h22));
    chk("t6_pop_req", 33'(rd_a), 33'(1));
    tick();
    chk("t6_beat2", 33'(md_a), 33'(8'h33));
    #2;
    rst = 1'b1;
    rst_req = 1'b1;
    #1;
    chk("t6_async_valid", 33'(mv_a), 33'(0));
    chk("t6_async_data", 33'(md_a), 33'(0));
    chk("t6_async_last", 33'(ml_a), 33'(0));
    chk("t6_async_count", 33'(bc_a), 33'(0));
    chk("t6_async_rd", 33'(rd_a), 33'(0));
    q_a.delete(); exp_a.delete(); q_b.delete(); exp_b.delete();
    hold_a = 1'b0; hold_b = 1'b0;
    tick();
    push_a(32'hDDCCBBAA);
    rst_req = 1'b0;
    tick();
    chk("t6_post_count", 33'(bc_a), 33'(0));
    chk("t6_post_rd", 33'(rd_a), 33'(1));
    tick();
    tick();
    chk("t6_restart_valid", 33'(mv_a), 33'(1));
    chk("t6_restart_beat0", 33'(md_a), 33'(8'hAA));
    drain_a(20);

    // RATIO=1 instance with ready toggling every cycle.
    f0 = fired_b;
    for (int i = 0; i < 12; i++) push_b($urandom);
    n = 0;
    while ((exp_b.size() != 0 || mv_b) && n < 200) begin
      mr_b_req = ~mr_b_req;
      tick();
      n++;
    end
    chk("b_drained", 33'(exp_b.size()), 33'(0));
    chk("b_beat_count", 33'(fired_b - f0), 33'(12));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
